// File: rtl/fetch_pkg.sv
// Shared constants and the prefetch-queue entry type for the fetch front end.
// Build option: FETCH_ADEL_EN adds an exception flag to each queue entry.
// With the flag, a redirect to a misaligned PC becomes an address-error entry.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
   localparam int          INST_BYTES       = 4;

   // Default entry layout for the 32-bit core. The top builds its own copy
   // sized by its parameters and hands it to the queue as a type parameter.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
`ifdef FETCH_ADEL_EN
      logic        exc;
`endif
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the instruction-SRAM, redirect and decode-handshake signals of the
// fetch unit. The master modport is the fetch unit side, and the slave
// modport is the environment side (SRAM, branch unit, decode).
// Build option: FETCH_ADEL_EN adds out_exc.
interface fetch_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic              inst_sram_en;
   logic [3:0]        inst_sram_wen;
   logic [ADDR_W-1:0] inst_sram_addr;
   logic [DATA_W-1:0] inst_sram_rdata;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_inst;
   logic [ADDR_W-1:0] out_pc;
`ifdef FETCH_ADEL_EN
   logic              out_exc;
`endif

   modport master (
      output inst_sram_en, inst_sram_wen, inst_sram_addr,
      input  inst_sram_rdata,
      input  redirect_valid, redirect_pc,
      output out_valid, out_inst, out_pc,
`ifdef FETCH_ADEL_EN
      output out_exc,
`endif
      input  out_ready
   );

   modport slave (
      input  inst_sram_en, inst_sram_wen, inst_sram_addr,
      output inst_sram_rdata,
      output redirect_valid, redirect_pc,
      input  out_valid, out_inst, out_pc,
`ifdef FETCH_ADEL_EN
      input  out_exc,
`endif
      output out_ready
   );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch entries. It has synchronous flush, push and pop.
// A flush has priority over a push or a pop in the same cycle.
// Build option: FETCH_ADEL_EN only changes the entry type passed in.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = fetch_entry_t,
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int CNT_W   = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             push_i,
   input  entry_t           push_data_i,
   input  logic             pop_i,
   output entry_t           head_o,
   output logic [CNT_W-1:0] count_o
);

   entry_t           mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_pop;

   // Next pointers and count. Pointers wrap naturally because DEPTH is a power of 2.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      do_pop   = pop_i & (count_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + CNT_W'(push_i) - CNT_W'(do_pop);
      end
   end

   // Pointer and count registers.
   // NOTE: state registers use non-blocking assignment, and comb logic uses blocking assignment.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage.
   // NOTE: storage is not reset. The count alone decides which slots hold live data.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end. It issues one SRAM read per cycle while the
// queue has room, tracks the single request in flight, and queues the
// responses for decode. A redirect flushes the queue and is issued the same cycle.
// Build option: FETCH_ADEL_EN turns a misaligned redirect into an
// address-error entry and halts fetch. Without it, redirect_pc[1:0] is
// forced to zero.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);

   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int OCC_W = CNT_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] inst;
`ifdef FETCH_ADEL_EN
      logic              exc;
`endif
   } entry_t;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] req_addr;
   logic [OCC_W-1:0]  occ;
   logic [CNT_W-1:0]  count;
   logic              req, pop, push, flush, misaligned, halted;
   entry_t            push_data, head;
`ifdef FETCH_ADEL_EN
   logic              halt_q, halt_d;
   logic              exc_pend_q, exc_pend_d;
`endif

   // The request decision, the response push and the next fetch state.
   // The stale response of a flushed request returns in the redirect cycle
   // itself, so the flush priority in the queue drops it. No separate kill
   // flop is needed.
   always_comb begin
      pop        = bus.out_valid & bus.out_ready;
      flush      = bus.redirect_valid;
      misaligned = 1'b0;
      halted     = 1'b0;
`ifdef FETCH_ADEL_EN
      misaligned = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
      halted     = halt_q;
      req_addr   = bus.redirect_valid ? bus.redirect_pc : fetch_pc_q;
`else
      req_addr   = bus.redirect_valid ? {bus.redirect_pc[ADDR_W-1:2], 2'b00} : fetch_pc_q;
`endif
      occ = OCC_W'(count) + OCC_W'(inflight_q) - OCC_W'(pop);
      // After a flush only the new request occupies a slot, so room is certain.
      if (bus.redirect_valid) req = !reset & !misaligned;
      else                    req = !reset & !halted & (occ < OCC_W'(DEPTH));

      push           = inflight_q & !flush;
      push_data.pc   = inflight_pc_q;
      push_data.inst = bus.inst_sram_rdata;
`ifdef FETCH_ADEL_EN
      push           = (inflight_q | exc_pend_q) & !flush;
      push_data.inst = exc_pend_q ? '0 : bus.inst_sram_rdata;
      push_data.exc  = exc_pend_q;
      halt_d         = bus.redirect_valid ? misaligned : halt_q;
      exc_pend_d     = misaligned;
`endif
      inflight_d    = req;
      inflight_pc_d = req_addr;
      fetch_pc_d    = req ? req_addr + ADDR_W'(INST_BYTES) : req_addr;
   end

   // Fetch-side state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
`ifdef FETCH_ADEL_EN
         halt_q        <= 1'b0;
         exc_pend_q    <= 1'b0;
`endif
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
`ifdef FETCH_ADEL_EN
         halt_q        <= halt_d;
         exc_pend_q    <= exc_pend_d;
`endif
      end
   end

   fetch_queue #(
      .DEPTH   (DEPTH),
      .entry_t (entry_t)
   ) u_queue (
      .clk         (clk),
      .reset       (reset),
      .flush_i     (flush),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (count)
   );

   assign bus.inst_sram_en   = req;
   assign bus.inst_sram_wen  = 4'b0000;
   assign bus.inst_sram_addr = req_addr;
   assign bus.out_valid      = (count != '0);
   assign bus.out_inst       = head.inst;
   assign bus.out_pc         = head.pc;
`ifdef FETCH_ADEL_EN
   assign bus.out_exc        = head.exc;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. It runs hand-derived cycle tables for
// the directed scenarios, then a randomized run checked against a queue-based
// reference model. When FETCH_ADEL_EN is defined it also runs the
// misaligned-redirect sequence.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int          ADDR_W = 32;
   localparam int          DATA_W = 32;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] B      = 32'hbfc00000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(B)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   // Instruction SRAM with 1-cycle read latency. Data returned = address ^ 0x55.
   always @(posedge clk)
      bus.inst_sram_rdata <= bus.inst_sram_en ? (bus.inst_sram_addr ^ 32'h55) : $urandom;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   typedef struct {
      logic        rst, rv;
      logic [31:0] rpc;
      logic        rdy, en;
      logic [31:0] addr;
      logic        chk, valid;
      logic [31:0] pc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit rst, bit rv, logic [31:0] rpc, bit rdy, bit en,
                               logic [31:0] addr, bit chk, bit valid, logic [31:0] pc);
      vec_t v;
      v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.en = en;
      v.addr = addr; v.chk = chk; v.valid = valid; v.pc = pc;
      return v;
   endfunction

   task automatic drive(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
      reset              = rst;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      bus.out_ready      = rdy;
   endtask

   task automatic apply(input int idx, input vec_t v);
      drive(v.rst, v.rv, v.rpc, v.rdy);
      #1;
      check($sformatf("tbl%0d_en", idx), bus.inst_sram_en, v.en);
      if (v.en) check($sformatf("tbl%0d_addr", idx), bus.inst_sram_addr, v.addr);
      if (v.chk) begin
         check($sformatf("tbl%0d_valid", idx), bus.out_valid, v.valid);
         if (v.valid) begin
            check($sformatf("tbl%0d_pc", idx), bus.out_pc, v.pc);
            check($sformatf("tbl%0d_inst", idx), bus.out_inst, v.pc ^ 32'h55);
`ifdef FETCH_ADEL_EN
            check($sformatf("tbl%0d_exc", idx), bus.out_exc, 1'b0);
`endif
         end
      end
      @(negedge clk);
   endtask

   typedef struct {
      logic [31:0] pc;
      int          rdy_at;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] mfetch;

   initial begin
      drive(1'b1, 1'b0, '0, 1'b0);
      @(negedge clk);
      @(negedge clk);

      // Steady fetch with decode always ready.
      vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0));
      vecs.push_back(mk(0,0,0,1, 1,B,       1,0,0));
      vecs.push_back(mk(0,0,0,1, 1,B+32'h4, 1,0,0));
      vecs.push_back(mk(0,0,0,1, 1,B+32'h8, 1,1,B));
      vecs.push_back(mk(0,0,0,1, 1,B+32'hc, 1,1,B+32'h4));
      vecs.push_back(mk(0,0,0,1, 1,B+32'h10,1,1,B+32'h8));
      // Decode stalled for 10 cycles: the queue fills to DEPTH, then drains in order.
      vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0, 1,B,       1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,B+32'h4, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,B+32'h8, 1,1,B));
      vecs.push_back(mk(0,0,0,0, 1,B+32'hc, 1,1,B));
      for (int i = 0; i < 6; i++) vecs.push_back(mk(0,0,0,0, 0,0, 1,1,B));
      for (int i = 0; i < 6; i++)
         vecs.push_back(mk(0,0,0,1, 1,B+32'h10+32'(4*i), 1,1,B+32'(4*i)));
      // Redirect with 3 entries queued and 1 in flight.
      vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0, 1,B,       1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,B+32'h4, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,B+32'h8, 1,1,B));
      vecs.push_back(mk(0,0,0,0, 1,B+32'hc, 1,1,B));
      vecs.push_back(mk(0,1,B+32'h100,0, 1,B+32'h100, 1,1,B));
      vecs.push_back(mk(0,0,0,0, 1,B+32'h104, 1,0,0));
      vecs.push_back(mk(0,0,0,1, 1,B+32'h108, 1,1,B+32'h100));
      vecs.push_back(mk(0,0,0,1, 1,B+32'h10c, 1,1,B+32'h104));
      vecs.push_back(mk(0,0,0,1, 1,B+32'h110, 1,1,B+32'h108));
      // Redirect in the same cycle as a pop: the pop is ignored.
      vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0));
      vecs.push_back(mk(0,0,0,1, 1,B,       1,0,0));
      vecs.push_back(mk(0,0,0,1, 1,B+32'h4, 1,0,0));
      vecs.push_back(mk(0,0,0,1, 1,B+32'h8, 1,1,B));
      vecs.push_back(mk(0,1,B+32'h200,1, 1,B+32'h200, 1,1,B+32'h4));
      vecs.push_back(mk(0,0,0,1, 1,B+32'h204, 1,0,0));
      vecs.push_back(mk(0,0,0,1, 1,B+32'h208, 1,1,B+32'h200));
      vecs.push_back(mk(0,0,0,1, 1,B+32'h20c, 1,1,B+32'h204));
`ifndef FETCH_ADEL_EN
      // Misaligned redirect target: the low two bits are dropped.
      vecs.push_back(mk(0,1,B+32'h302,1, 1,B+32'h300, 1,1,B+32'h208));
      vecs.push_back(mk(0,0,0,1, 1,B+32'h304, 1,0,0));
      vecs.push_back(mk(0,0,0,1, 1,B+32'h308, 1,1,B+32'h300));
`endif
      // Reset for one cycle while the queue is full.
      vecs.push_back(mk(1,0,0,0, 0,0, 0,0,0));
      vecs.push_back(mk(0,0,0,0, 1,B,       1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,B+32'h4, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,B+32'h8, 1,1,B));
      vecs.push_back(mk(0,0,0,0, 1,B+32'hc, 1,1,B));
      vecs.push_back(mk(0,0,0,0, 0,0, 1,1,B));
      vecs.push_back(mk(0,0,0,0, 0,0, 1,1,B));
      vecs.push_back(mk(1,0,0,0, 0,0, 1,1,B));
      vecs.push_back(mk(0,0,0,0, 1,B,       1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,B+32'h4, 1,0,0));
      vecs.push_back(mk(0,0,0,0, 1,B+32'h8, 1,1,B));

      foreach (vecs[i]) apply(i, vecs[i]);

`ifdef FETCH_ADEL_EN
      // A misaligned redirect yields one exception entry, then fetch halts.
      drive(1, 0, '0, 1); @(negedge clk);
      for (int i = 0; i < 4; i++) begin drive(0, 0, '0, 1); @(negedge clk); end
      drive(0, 1, B+32'h102, 1); #1;
      check("adel_req_en", bus.inst_sram_en, 1'b0);
      @(negedge clk);
      drive(0, 0, '0, 1); #1;
      check("adel_gap_valid", bus.out_valid, 1'b0);
      check("adel_gap_en", bus.inst_sram_en, 1'b0);
      @(negedge clk); #1;
      check("adel_valid", bus.out_valid, 1'b1);
      check("adel_pc", bus.out_pc, B+32'h102);
      check("adel_exc", bus.out_exc, 1'b1);
      check("adel_inst", bus.out_inst, 32'h0);
      check("adel_halt_en", bus.inst_sram_en, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check("adel_halt_en", bus.inst_sram_en, 1'b0);
         check("adel_halt_valid", bus.out_valid, 1'b0);
      end
      @(negedge clk);
      drive(0, 1, B+32'h200, 1); #1;
      check("adel_resume_en", bus.inst_sram_en, 1'b1);
      check("adel_resume_addr", bus.inst_sram_addr, B+32'h200);
      @(negedge clk);
      drive(0, 0, '0, 1); @(negedge clk); #1;
      check("adel_resume_pc", bus.out_pc, B+32'h200);
      check("adel_resume_exc", bus.out_exc, 1'b0);
      @(negedge clk);
`endif

      // Randomized run against the reference model. Each request becomes an
      // entry visible two cycles later. A redirect discards every outstanding
      // entry, and a pop takes the oldest entry.
      for (int n = 0; n < 3000; n++) begin
         bit          rst, rv, rdy, exp_valid, exp_pop, exp_en;
         logic [31:0] rpc, exp_addr;
         rst = (n == 0) || ($urandom_range(0, 199) == 0);
         rv  = !rst && ($urandom_range(0, 19) == 0);
         rpc = B + ($urandom_range(0, 255) << 2);
`ifndef FETCH_ADEL_EN
         rpc[1:0] = 2'($urandom_range(0, 3));
`endif
         rdy = ($urandom_range(0, 3) != 0);
         drive(rst, rv, rpc, rdy);
         #1;
         if (rst) begin
            check("rnd_rst_en", bus.inst_sram_en, 1'b0);
            mq.delete();
            mfetch = B;
         end else begin
            exp_valid = (mq.size() > 0) && (mq[0].rdy_at <= n);
            exp_pop   = exp_valid && rdy;
            exp_addr  = rv ? {rpc[31:2], 2'b00} : mfetch;
            exp_en    = rv || ((mq.size() - int'(exp_pop)) < DEPTH);
            check("rnd_en", bus.inst_sram_en, exp_en);
            if (exp_en) check("rnd_addr", bus.inst_sram_addr, exp_addr);
            check("rnd_valid", bus.out_valid, exp_valid);
            if (exp_valid) begin
               check("rnd_pc", bus.out_pc, mq[0].pc);
               check("rnd_inst", bus.out_inst, mq[0].pc ^ 32'h55);
`ifdef FETCH_ADEL_EN
               check("rnd_exc", bus.out_exc, 1'b0);
`endif
            end
            if (rv) mq.delete();
            else if (exp_pop) void'(mq.pop_front());
            if (exp_en) begin
               ent_t e;
               e.pc = exp_addr;
               e.rdy_at = n + 2;
               mq.push_back(e);
               mfetch = exp_addr + 32'd4;
            end else begin
               mfetch = exp_addr;
            end
         end
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
